// File: rtl/imm_pack_if.sv
// Handshake bundle for the immediate packer: request side (in_*) and
// result side (out_*, err_count).
interface imm_pack_if #(
   parameter int CNTW = 16
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [31:0]     in_imm;
   logic [2:0]      in_immsrc;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_instr;
   logic            out_err;
   logic [CNTW-1:0] err_count;

   modport master (
      output in_valid, in_instr, in_imm, in_immsrc, out_ready,
      input  in_ready, out_valid, out_instr, out_err, err_count
   );

   modport slave (
      input  in_valid, in_instr, in_imm, in_immsrc, out_ready,
      output in_ready, out_valid, out_instr, out_err, err_count
   );
endinterface

// File: rtl/imm_pack.sv
// Immediate packer: scatters an immediate into RV32I I/S/B/J/U positions of a
// template, flags unrepresentable immediates, and queues results in a small FIFO.
module imm_pack #(
   parameter int DEPTH = 2,
   parameter int CNTW  = 16
) (
   input logic        clk,
   input logic        reset_n,
   imm_pack_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [2:0] SRC_I = 3'b000;
   localparam logic [2:0] SRC_S = 3'b001;
   localparam logic [2:0] SRC_B = 3'b010;
   localparam logic [2:0] SRC_J = 3'b011;
   localparam logic [2:0] SRC_U = 3'b100;

   logic [31:0]     packed_instr;
   logic            packed_err;
   logic [31:0]     imm;
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic [32:0]     mem [DEPTH];
   logic [32:0]     head;
   logic [CNTW-1:0] err_cnt;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;

   assign imm = bus.in_imm;

   // Illegal immediates still get their truncated bits packed; only err flags them.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      packed_instr = bus.in_instr;
      packed_err   = 1'b0;
      case (bus.in_immsrc)
         SRC_I: begin
            packed_instr[31:20] = imm[11:0];
            packed_err          = !((&imm[31:11]) || !(|imm[31:11]));
         end
         SRC_S: begin
            packed_instr[31:25] = imm[11:5];
            packed_instr[11:7]  = imm[4:0];
            packed_err          = !((&imm[31:11]) || !(|imm[31:11]));
         end
         SRC_B: begin
            packed_instr[31]    = imm[12];
            packed_instr[7]     = imm[11];
            packed_instr[30:25] = imm[10:5];
            packed_instr[11:8]  = imm[4:1];
            packed_err          = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
         end
         SRC_J: begin
            packed_instr[31]    = imm[20];
            packed_instr[19:12] = imm[19:12];
            packed_instr[20]    = imm[11];
            packed_instr[30:21] = imm[10:1];
            packed_err          = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
         end
         SRC_U: begin
            packed_instr[31:12] = imm[31:12];
            packed_err          = |imm[11:0];
         end
         default: begin
            packed_instr = bus.in_instr;
            packed_err   = 1'b1;
         end
      endcase
   end

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push  = bus.in_valid && !full;
   assign pop   = !empty && bus.out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; outputs are masked while empty instead.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {packed_err, packed_instr};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_cnt <= '0;
      end else if (push && packed_err && (err_cnt != {CNTW{1'b1}})) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

   assign head          = mem[rd_ptr[AW-1:0]];
   assign bus.in_ready  = !full;
   assign bus.out_valid = !empty;
   assign bus.out_instr = empty ? 32'h0 : head[31:0];
   assign bus.out_err   = empty ? 1'b0  : head[32];
   assign bus.err_count = err_cnt;
endmodule

// File: doc/imm_pack.md
# imm_pack

Immediate packer: the encode direction of the core's immediate field handling. It accepts a 32-bit instruction template, a 32-bit immediate value and a format select, and scatters the immediate bits into the RV32I positions for I/S/B/J/U formats. It also flags immediates that the format cannot represent. Results pass through a small registered FIFO with valid/ready handshakes on both sides. It sits between the test-program generator / debug instruction injector and instruction memory.

## Interface
- DEPTH, 2, output FIFO entries; power of two, ≥2
- CNTW, 16, width of saturating error counter
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  FIFO can accept (not full)
- in_instr  input  32  template; bits not covered by the immediate pass through
- in_imm  input  32  immediate value, two's complement
- in_immsrc  input  3  000 I, 001 S, 010 B, 011 J, 100 U, 101–111 illegal
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head entry
- out_instr  output  32  packed instruction (head entry)
- out_err  output  1  head entry had unrepresentable immediate or illegal immsrc
- err_count  output  CNTW  accepted requests with err=1, saturating

## Operation
- Packing, combinational on inputs, written into FIFO on push:
  - I: instr[31:20]=imm[11:0]; legal iff imm[31:11] all equal.
  - S: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0]; legal iff imm[31:11] all equal.
  - B: instr[31]=imm[12], instr[7]=imm[11], instr[30:25]=imm[10:5], instr[11:8]=imm[4:1]; legal iff imm[31:12] all equal and imm[0]=0.
  - J: instr[31]=imm[20], instr[19:12]=imm[19:12], instr[20]=imm[11], instr[30:21]=imm[10:1]; legal iff imm[31:20] all equal and imm[0]=0.
  - U: instr[31:12]=imm[31:12]; legal iff imm[11:0]=0.
  - Illegal immsrc: instr=in_instr unchanged, err=1.
  - All other template bits are copied unchanged.
  - On an illegal immediate, the truncated bits are still packed exactly as above; err=1.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- FIFO: read/write pointers of log2(DEPTH)+1 bits; wrap modulo DEPTH; full when the low bits are equal and the MSBs differ.
- in_ready = !full. It is not combinationally dependent on out_ready, so no push occurs while full even if a pop happens the same cycle.
- Simultaneous push and pop when neither empty nor full: occupancy unchanged, order preserved.
- out_instr/out_err are held stable while out_valid & !out_ready.
- err_count increments on each push with err=1 and saturates at 2^CNTW−1.
- Reset (async assert, sync-safe deassert by the system): pointers 0, FIFO empty.
  - Reset values: in_ready=1, out_valid=0, out_instr=0, out_err=0, err_count=0.
  - Entries in flight are discarded.

## Timing
- Latency 1 cycle: push at edge N → out_valid=1 after edge N when the FIFO was empty.
- Throughput: 1 request/cycle while out_ready=1.
- in_ready, out_valid and the FIFO contents are register-driven. out_instr/out_err are a mux of FIFO storage by the read pointer, with no combinational path from in_* to out_*.
- Reset asserted mid-transfer: all outputs reach reset values immediately, without waiting for a clock.

## Test plan
- I-type: template 0x00000013, imm 0xFFFFFFFF → out_instr 0xFFF00013, out_err 0, one cycle later.
- B-type: template 0x00000063, imm 0x00000800 → 0x000000E3, err 0; imm 0x00001000 → err 1, out_instr 0x80000063.
- J-type odd: template 0x0000006F, imm 0x00000003 → 0x0020006F, err 1, err_count 1. U-type: template 0x00000037, imm 0x12345000 → 0x12345037, err 0.
- Backpressure, DEPTH=2: out_ready=0, three back-to-back requests → in_ready low after the 2nd push, 3rd held. Then raise out_ready → outputs in order, 3rd accepted, no loss or duplication.
- Illegal immsrc 101, template 0xDEADBEEF → out_instr 0xDEADBEEF, err 1. Force err_count to saturate (CNTW=4, 17 errors) → holds 0xF.
- Assert reset_n=0 with 2 entries queued → out_valid 0 and err_count 0 immediately; after release, first new request emerges correctly.
